// File: rtl/wakeup_debounce.sv
// Wakeup push-button conditioner: synchronises the raw pad level into the
// hfextclk domain, debounces press and release, and drives a clean,
// stretched active-low wakeup level plus a press pulse and an event count.
module wakeup_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int MIN_ASSERT      = 1024,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    output logic       dwakeup_n_o,
    output logic       wake_pulse_o,
    output logic       busy_o,
    output logic [7:0] event_cnt_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        QUAL_PRESS = 2'd1,
        ASSERT     = 2'd2,
        QUAL_REL   = 2'd3
    } state_t;

    // Terminal counts for the shared down-time counter.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ASR_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    assign s = sync[SYNC_STAGES-1];

    // Metastability chain for the asynchronous pad level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_i};
        end
    end

    // Debounce FSM. Outputs are registered alongside the state so each one
    // changes on the same edge as the transition that defines it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dwakeup_n_o  <= 1'b1;
            wake_pulse_o <= 1'b0;
            busy_o       <= 1'b0;
            event_cnt_o  <= '0;
        end else begin
            wake_pulse_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state  <= QUAL_PRESS;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                QUAL_PRESS: begin
                    if (!s) begin
                        // Bounce: drop back without any visible effect.
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        state        <= ASSERT;
                        cnt          <= '0;
                        dwakeup_n_o  <= 1'b0;
                        wake_pulse_o <= 1'b1;
                        event_cnt_o  <= event_cnt_o + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ASSERT: begin
                    // Stretch: count saturates, release is only looked at
                    // once the minimum low time has been served.
                    if (cnt != ASR_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end else if (!s) begin
                        state <= QUAL_REL;
                        cnt   <= '0;
                    end
                end
                QUAL_REL: begin
                    if (s) begin
                        // Release bounce; minimum time already met, so
                        // re-enter saturated and without a new pulse.
                        state <= ASSERT;
                        cnt   <= ASR_LAST;
                    end else if (cnt == DEB_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        dwakeup_n_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    dwakeup_n_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
